gpio_register_ip: RTL and testbench
===================================

// Module: gpio_register_ip
//
// PURPOSE
// Memory-mapped 32-bit GPIO register block on a simple single-cycle register bus.
// It holds an output-data register and a per-pin direction register, and drives the pad outputs and output enables.
// Pad inputs pass through a 2-flop synchronizer; the composite pin state is readable at offset 0x8.
// It sits between the CPU peripheral bus decoder and the GPIO pads.
//
// PARAMETERS
// GPIO_W   32   number of GPIO pins; register width; must be <= 32, unused upper bits read 0
//
// PORTS
// clk          in   1       system clock; all state updates on rising edge
// rst_n        in   1       synchronous reset, active low
// en           in   1       bus select; no access when 0
// wr           in   1       1 = write, 0 = read (valid only when en = 1)
// addr_offset  in   8       byte offset of the register within the block
// data_in      in   32      write data
// data_out     out  32      read data (combinational)
// gpio_in      in   GPIO_W  asynchronous pad inputs
// gpio_out     out  GPIO_W  pad output values (= DATA register)
// gpio_oe      out  GPIO_W  pad output enables (= DIR register; 1 = drive)
//
// BEHAVIOUR
// Interface: one clock (clk); reset is synchronous and active-low (rst_n).
// Register map, full 8-bit decode; any other offset, including misaligned ones, is unmapped:
//   0x00 DATA  RW  output data; reset 0x00000000
//   0x04 DIR   RW  direction, bit=1 output, bit=0 input; reset 0x00000000 (all inputs)
//   0x08 PINS  RO  composite pin state = (DIR & DATA) | (~DIR & gpio_in_sync)
// Reset, on a clk edge with rst_n = 0:
//   - DATA, DIR and both synchronizer stages clear to 0.
//   - Reset has priority over any write in the same cycle.
//   - gpio_out = 0 and gpio_oe = 0 during and after reset.
// Write: on a rising clk edge with en = 1 and wr = 1, data_in[GPIO_W-1:0] loads the addressed register.
//   - The new value is visible on gpio_out/gpio_oe and on readback from the next cycle.
//   - Writes to PINS or to unmapped offsets are ignored and have no side effects.
// Read: when en = 1 and wr = 0, data_out shows the addressed register combinationally, zero-wait.
//   - Unmapped offsets read 0x00000000.
//   - When en = 0, or during a write (wr = 1), data_out = 0x00000000.
//   - A read in the same cycle as a write to the same register shows the old value (write lands at the edge).
// Synchronizer: gpio_in -> sync1 -> sync2 each clk. PINS input bits lag a pad change by 2 cycles.
//   - Output bits (DIR = 1) reflect DATA directly, with no lag.
// DIR change: a pin switched to input reads the synchronized pad value immediately, using the already-running sync chain.
// No interrupts and no set/clear aliases. Bus errors are never signalled.
//
// TESTING
// 1. Reset: rst_n = 0 for 2 cycles, then en = 1, wr = 0 -> reads at 0x0/0x4 = 0x00000000; gpio_oe = 0.
// 2. Write DATA = 0xA5A5A5A5 @0x0, then DIR = 0xFFFFFFF0 @0x4 -> readback 0xA5A5A5A5 / 0xFFFFFFF0;
//    gpio_out = 0xA5A5A5A5, gpio_oe = 0xFFFFFFF0.
// 3. State of test 2 with gpio_in = 0x0000000C held >= 2 cycles -> read @0x8 = 0xA5A5A5AC.
// 4. Toggle gpio_in[0] 0 -> 1 -> read @0x8 bit0 is 0 for the first 2 edges and 1 after the 2nd edge.
// 5. Write 0x12345678 @0x8 and @0x10, and a read with en = 0 -> DATA/DIR unchanged;
//    read 0x8 unchanged by the write; read 0x10 = 0; data_out = 0 while en = 0.
// 6. Assert rst_n = 0 on the same edge as a write @0x0 -> DATA = 0 afterwards; gpio_out = 0.

Source files
------------

// File: rtl/gpio_register_ip.sv
// Memory-mapped GPIO block: DATA/DIR registers, pad drive, 2-flop input sync,
// composite PINS readback. One pin_cell instance per GPIO pin.

module gpio_pin_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic data_we,
  input  logic dir_we,
  input  logic data_d,
  input  logic dir_d,
  input  logic pad,
  output logic data_q,
  output logic dir_q,
  output logic pin
);
  logic sync1, sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= 1'b0;
      dir_q  <= 1'b0;
      sync1  <= 1'b0;
      sync2  <= 1'b0;
    end else begin
      if (data_we) data_q <= data_d;
      if (dir_we)  dir_q  <= dir_d;
      sync1 <= pad;
      sync2 <= sync1;
    end
  end

  // Driven pins read back DATA with no lag; input pins read the sync chain.
  assign pin = dir_q ? data_q : sync2;
endmodule

module gpio_register_ip #(
  parameter int GPIO_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wr,
  input  logic [7:0]        addr_offset,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe
);
  localparam logic [7:0] OFF_DATA = 8'h00;
  localparam logic [7:0] OFF_DIR  = 8'h04;
  localparam logic [7:0] OFF_PINS = 8'h08;

  logic              data_we, dir_we;
  logic [GPIO_W-1:0] data_reg, dir_reg, pins;

  assign data_we = en && wr && (addr_offset == OFF_DATA);
  assign dir_we  = en && wr && (addr_offset == OFF_DIR);

  genvar i;
  generate
    for (i = 0; i < GPIO_W; i++) begin : g_pin
      gpio_pin_cell u_cell (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_we (data_we),
        .dir_we  (dir_we),
        .data_d  (data_in[i]),
        .dir_d   (data_in[i]),
        .pad     (gpio_in[i]),
        .data_q  (data_reg[i]),
        .dir_q   (dir_reg[i]),
        .pin     (pins[i])
      );
    end
  endgenerate

  assign gpio_out = data_reg;
  assign gpio_oe  = dir_reg;

  // Reads are zero-wait; idle, write cycles and unmapped offsets return 0.
  always_comb begin
    data_out = '0;
    if (en && !wr) begin
      case (addr_offset)
        OFF_DATA: data_out[GPIO_W-1:0] = data_reg;
        OFF_DIR:  data_out[GPIO_W-1:0] = dir_reg;
        OFF_PINS: data_out[GPIO_W-1:0] = pins;
        default:  data_out = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_gpio_register_ip.sv
// Directed bench for gpio_register_ip: inputs driven on negedge, outputs checked mid-low-phase.

module tb_gpio_register_ip;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, wr;
  logic [7:0]  addr_offset;
  logic [31:0] data_in, data_out;
  logic [31:0] gpio_in, gpio_out, gpio_oe;

  int tests = 0;
  int fails = 0;

  gpio_register_ip #(.GPIO_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr(wr), .addr_offset(addr_offset),
    .data_in(data_in), .data_out(data_out), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe)
  );

  always #5 clk = ~clk;

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wr = 1'b1; addr_offset = a; data_in = d;
    #1;
    tests++;
    if (data_out !== 32'h0) begin
      fails++; $display("FAIL write_data_out_zero got=%h exp=%h", data_out, 32'h0);
    end
    @(posedge clk);
    #1;
    en = 1'b0; wr = 1'b0; data_in = '0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr_offset = a;
    #1;
    d = data_out;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst_n = 1'b0; en = 1'b1; wr = 1'b1; addr_offset = 8'h00; data_in = 32'hFFFF_FFFF; gpio_in = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (gpio_out !== 32'h0 || gpio_oe !== 32'h0) begin
      fails++; $display("FAIL reset_pads got=%h/%h exp=0/0", gpio_out, gpio_oe);
    end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0; wr = 1'b0; data_in = '0;
    do_read(8'h00, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL reset_data got=%h exp=%h", r, 32'h0); end
    do_read(8'h04, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL reset_dir got=%h exp=%h", r, 32'h0); end
    tests++;
    if (gpio_oe !== 32'h0) begin fails++; $display("FAIL reset_oe got=%h exp=%h", gpio_oe, 32'h0); end
  endtask

  task automatic test_write_readback();
    logic [31:0] r;
    do_write(8'h00, 32'hA5A5_A5A5);
    do_write(8'h04, 32'hFFFF_FFF0);
    do_read(8'h00, r);
    tests++;
    if (r !== 32'hA5A5_A5A5) begin fails++; $display("FAIL rb_data got=%h exp=%h", r, 32'hA5A5_A5A5); end
    do_read(8'h04, r);
    tests++;
    if (r !== 32'hFFFF_FFF0) begin fails++; $display("FAIL rb_dir got=%h exp=%h", r, 32'hFFFF_FFF0); end
    tests++;
    if (gpio_out !== 32'hA5A5_A5A5 || gpio_oe !== 32'hFFFF_FFF0) begin
      fails++; $display("FAIL pads got=%h/%h exp=a5a5a5a5/fffffff0", gpio_out, gpio_oe);
    end
  endtask

  task automatic test_pins();
    logic [31:0] r;
    @(negedge clk);
    gpio_in = 32'h0000_000C;
    repeat (3) @(posedge clk);
    do_read(8'h08, r);
    tests++;
    if (r !== 32'hA5A5_A5AC) begin fails++; $display("FAIL pins_comp got=%h exp=%h", r, 32'hA5A5_A5AC); end
  endtask

  task automatic test_sync_lag();
    @(negedge clk);
    gpio_in = 32'h0000_000D;
    en = 1'b1; wr = 1'b0; addr_offset = 8'h08;
    #1;
    tests++;
    if (data_out[0] !== 1'b0) begin fails++; $display("FAIL lag_e0 got=%b exp=0", data_out[0]); end
    @(negedge clk); #1;
    tests++;
    if (data_out[0] !== 1'b0) begin fails++; $display("FAIL lag_e1 got=%b exp=0", data_out[0]); end
    @(negedge clk); #1;
    tests++;
    if (data_out[0] !== 1'b1) begin fails++; $display("FAIL lag_e2 got=%b exp=1", data_out[0]); end
  endtask

  task automatic test_unmapped();
    logic [31:0] r;
    do_write(8'h08, 32'h1234_5678);
    do_write(8'h10, 32'h1234_5678);
    do_write(8'h01, 32'h1234_5678);
    do_read(8'h00, r);
    tests++;
    if (r !== 32'hA5A5_A5A5) begin fails++; $display("FAIL um_data got=%h exp=%h", r, 32'hA5A5_A5A5); end
    do_read(8'h04, r);
    tests++;
    if (r !== 32'hFFFF_FFF0) begin fails++; $display("FAIL um_dir got=%h exp=%h", r, 32'hFFFF_FFF0); end
    do_read(8'h08, r);
    tests++;
    if (r !== 32'hA5A5_A5AD) begin fails++; $display("FAIL um_pins got=%h exp=%h", r, 32'hA5A5_A5AD); end
    do_read(8'h10, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL um_rd10 got=%h exp=%h", r, 32'h0); end
    do_read(8'h05, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL um_misalign got=%h exp=%h", r, 32'h0); end
    @(negedge clk);
    en = 1'b0; wr = 1'b0; addr_offset = 8'h00;
    #1;
    tests++;
    if (data_out !== 32'h0) begin fails++; $display("FAIL en_low got=%h exp=%h", data_out, 32'h0); end
  endtask

  task automatic test_dir_change();
    logic [31:0] r;
    do_write(8'h04, 32'h0000_000F);
    do_read(8'h08, r);
    tests++;
    if (r !== 32'h0000_0005) begin fails++; $display("FAIL dir_flip got=%h exp=%h", r, 32'h0000_0005); end
    tests++;
    if (gpio_oe !== 32'h0000_000F) begin fails++; $display("FAIL dir_flip_oe got=%h exp=%h", gpio_oe, 32'h0000_000F); end
  endtask

  task automatic test_reset_vs_write();
    logic [31:0] r;
    @(negedge clk);
    rst_n = 1'b0; en = 1'b1; wr = 1'b1; addr_offset = 8'h00; data_in = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    tests++;
    if (gpio_out !== 32'h0 || gpio_oe !== 32'h0) begin
      fails++; $display("FAIL rst_prio_pads got=%h/%h exp=0/0", gpio_out, gpio_oe);
    end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0; wr = 1'b0; data_in = '0;
    do_read(8'h00, r);
    tests++;
    if (r !== 32'h0) begin fails++; $display("FAIL rst_prio_data got=%h exp=%h", r, 32'h0); end
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(posedge clk);
    do_read(8'h08, r);
    tests++;
    if (r !== 32'h0000_000D) begin fails++; $display("FAIL rst_pins_resync got=%h exp=%h", r, 32'h0000_000D); end
  endtask

  initial begin
    en = 1'b0; wr = 1'b0; addr_offset = '0; data_in = '0; gpio_in = '0; rst_n = 1'b0;
    test_reset();
    test_write_readback();
    test_pins();
    test_sync_lag();
    test_unmapped();
    test_dir_change();
    test_reset_vs_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
